// File: rtl/riscv_trace_fifo_if.sv
// riscv_trace_fifo_if: valid/ready head-record port of the trace FIFO
interface riscv_trace_fifo_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int TS_W   = 16
);
  logic              out_valid;
  logic              out_ready;
  logic [TS_W-1:0]   out_ts;
  logic              out_reg_we;
  logic [4:0]        out_reg_num;
  logic [DATA_W-1:0] out_reg_data;
  logic              out_mem_wr;
  logic              out_mem_rd;
  logic [ADDR_W-1:0] out_mem_addr;
  logic [DATA_W-1:0] out_mem_data;
  modport master (
    output out_valid, out_ts, out_reg_we, out_reg_num, out_reg_data,
           out_mem_wr, out_mem_rd, out_mem_addr, out_mem_data,
    input  out_ready
  );
  modport slave (
    input  out_valid, out_ts, out_reg_we, out_reg_num, out_reg_data,
           out_mem_wr, out_mem_rd, out_mem_addr, out_mem_data,
    output out_ready
  );
endinterface

// File: rtl/riscv_trace_fifo.sv
// riscv_trace_fifo: timestamped writeback/memory trace capture into a first-word fall-through FIFO
module riscv_trace_fifo #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     trace_en,
  input  logic                     reg_write_sig,
  input  logic [4:0]               reg_num,
  input  logic [DATA_W-1:0]        reg_data,
  input  logic                     wr,
  input  logic                     rd,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [DATA_W-1:0]        rd_data,
  riscv_trace_fifo_if.master       o,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              drop_count,
  output logic                     overflow
);
  localparam int PW = $clog2(DEPTH);
  typedef struct packed {
    logic [TS_W-1:0]   ts;
    logic              reg_we;
    logic [4:0]        reg_num;
    logic [DATA_W-1:0] reg_data;
    logic              mem_wr;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
  } rec_t;
  rec_t          mem_q [DEPTH];
  rec_t          rec, head_rec;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PW:0]   level_q, level_d;
  logic [TS_W-1:0] ts_q, ts_d;
  logic [15:0]   drop_q, drop_d;
  logic          ovf_q, ovf_d;
  logic          reg_we, ev, full, valid, pop, push, drop;
  always_comb begin
    reg_we        = reg_write_sig & (reg_num != 5'd0);
    ev            = trace_en & (reg_we | wr | rd);
    valid         = level_q != '0;
    full          = level_q[PW];
    pop           = valid & o.out_ready;
    push          = ev & (~full | pop);
    drop          = ev & full & ~pop;
    rec.ts        = ts_q;
    rec.reg_we    = reg_we;
    rec.reg_num   = reg_we ? reg_num : 5'd0;
    rec.reg_data  = reg_we ? reg_data : '0;
    rec.mem_wr    = wr;
    rec.mem_rd    = rd & ~wr;
    rec.mem_addr  = (wr | rd) ? addr : '0;
    rec.mem_data  = wr ? wr_data : rd ? rd_data : '0;
    head_d        = head_q + PW'(pop);
    tail_d        = tail_q + PW'(push);
    level_d       = level_q + (PW+1)'(push) - (PW+1)'(pop);
    ts_d          = ts_q + TS_W'(1);
    drop_d        = (drop & ~&drop_q) ? drop_q + 16'd1 : drop_q;
    ovf_d         = ovf_q | drop;
    head_rec      = valid ? mem_q[head_q] : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      level_q <= '0;
      ts_q    <= '0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      level_q <= level_d;
      ts_q    <= ts_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
    end
  end
  always_ff @(posedge clk) if (push) mem_q[tail_q] <= rec;
  assign o.out_valid    = valid;
  assign o.out_ts       = head_rec.ts;
  assign o.out_reg_we   = head_rec.reg_we;
  assign o.out_reg_num  = head_rec.reg_num;
  assign o.out_reg_data = head_rec.reg_data;
  assign o.out_mem_wr   = head_rec.mem_wr;
  assign o.out_mem_rd   = head_rec.mem_rd;
  assign o.out_mem_addr = head_rec.mem_addr;
  assign o.out_mem_data = head_rec.mem_data;
  assign level          = level_q;
  assign drop_count     = drop_q;
  assign overflow       = ovf_q;
endmodule

// File: tb/tb_riscv_trace_fifo.sv
// tb_riscv_trace_fifo: randomized scoreboard bench for riscv_trace_fifo against a queue model
module tb_riscv_trace_fifo;
  localparam int DEPTH = 16;
  typedef struct packed {
    logic [15:0] ts;
    logic        reg_we;
    logic [4:0]  reg_num;
    logic [31:0] reg_data;
    logic        mem_wr;
    logic        mem_rd;
    logic [8:0]  mem_addr;
    logic [31:0] mem_data;
  } rec_t;
  logic        clk = 0;
  logic        reset, trace_en, reg_write_sig, wr, rd;
  logic [4:0]  reg_num;
  logic [31:0] reg_data, wr_data, rd_data;
  logic [8:0]  addr;
  logic [4:0]  level;
  logic [15:0] drop_count;
  logic        overflow;
  int          vectors = 0, miscompares = 0;
  rec_t        exp_q[$];
  logic [15:0] m_ts, m_drop;
  logic        m_ovf;
  logic        pend_pop = 0, started = 0;
  riscv_trace_fifo_if #(.DATA_W(32), .ADDR_W(9), .TS_W(16)) tif ();
  riscv_trace_fifo #(.DATA_W(32), .ADDR_W(9), .DEPTH(DEPTH), .TS_W(16)) dut (
    .clk(clk), .reset(reset), .trace_en(trace_en), .reg_write_sig(reg_write_sig),
    .reg_num(reg_num), .reg_data(reg_data), .wr(wr), .rd(rd), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .o(tif.master), .level(level),
    .drop_count(drop_count), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(string nm, logic [127:0] act, logic [127:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, want);
    end
  endtask
  function automatic rec_t expect_rec();
    rec_t r;
    logic we;
    we         = reg_write_sig && reg_num != 0;
    r.ts       = m_ts;
    r.reg_we   = we;
    r.reg_num  = we ? reg_num : 5'd0;
    r.reg_data = we ? reg_data : 32'd0;
    r.mem_wr   = wr;
    r.mem_rd   = rd && !wr;
    r.mem_addr = (wr || rd) ? addr : 9'd0;
    r.mem_data = wr ? wr_data : (rd ? rd_data : 32'd0);
    return r;
  endfunction
  always @(posedge clk) begin
    int n;
    if (reset) begin
      exp_q.delete();
      m_ts = 0;
      m_drop = 0;
      m_ovf = 0;
    end else begin
      n = exp_q.size() + int'(pend_pop);
      if (trace_en && ((reg_write_sig && reg_num != 0) || wr || rd)) begin
        if (n < DEPTH || pend_pop) exp_q.push_back(expect_rec());
        else begin
          if (m_drop != 16'hFFFF) m_drop++;
          m_ovf = 1;
        end
      end
      m_ts++;
    end
    started = 1;
  end
  always @(negedge clk) begin
    rec_t got, want;
    if (started) begin
      got = {tif.out_ts, tif.out_reg_we, tif.out_reg_num, tif.out_reg_data,
             tif.out_mem_wr, tif.out_mem_rd, tif.out_mem_addr, tif.out_mem_data};
      want = exp_q.size() != 0 ? exp_q[0] : '0;
      chk("level", 128'(level), 128'(exp_q.size()));
      chk("out_valid", 128'(tif.out_valid), 128'(exp_q.size() != 0));
      chk("drop_count", 128'(drop_count), 128'(m_drop));
      chk("overflow", 128'(overflow), 128'(m_ovf));
      chk("head_record", 128'(got), 128'(want));
      pend_pop = 0;
      if (tif.out_ready && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        pend_pop = 1;
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    reg_write_sig = 0; reg_num = 0; reg_data = 0; wr = 0; rd = 0;
    addr = 0; wr_data = 0; rd_data = 0;
  endtask
  task automatic drain();
    tif.out_ready = 1;
    for (int k = 0; k < 40 && tif.out_valid; k++) step();
    chk("drain_empty", 128'(tif.out_valid), 128'(0));
    tif.out_ready = 0;
  endtask
  initial begin
    reset = 1; trace_en = 1; tif.out_ready = 0;
    idle();
    repeat (2) step();
    reset = 0;
    repeat (3) step();
    reg_write_sig = 1; reg_num = 5; reg_data = 32'hDEADBEEF;
    step();
    idle();
    @(negedge clk);
    chk("t1_ts", 128'(tif.out_ts), 128'(3));
    chk("t1_reg_num", 128'(tif.out_reg_num), 128'(5));
    chk("t1_reg_data", 128'(tif.out_reg_data), 128'(32'hDEADBEEF));
    chk("t1_level", 128'(level), 128'(1));
    drain();
    reg_write_sig = 1; reg_num = 0; reg_data = 32'h55;
    step();
    idle();
    @(negedge clk);
    chk("t2_x0_level", 128'(level), 128'(0));
    reg_write_sig = 1; reg_num = 0; wr = 1; addr = 9'h1F0; wr_data = 32'h12345678;
    step();
    idle();
    @(negedge clk);
    chk("t2_reg_we", 128'(tif.out_reg_we), 128'(0));
    chk("t2_mem_wr", 128'(tif.out_mem_wr), 128'(1));
    chk("t2_mem_data", 128'(tif.out_mem_data), 128'(32'h12345678));
    drain();
    for (int i = 0; i < 20; i++) begin
      wr = 1; addr = 9'($urandom); wr_data = i;
      step();
    end
    idle();
    @(negedge clk);
    chk("t3_level", 128'(level), 128'(16));
    chk("t3_drop", 128'(drop_count), 128'(4));
    chk("t3_ovf", 128'(overflow), 128'(1));
    wr = 1; wr_data = 32'hAAAA5555; tif.out_ready = 1;
    step();
    idle();
    tif.out_ready = 0;
    @(negedge clk);
    chk("t4_level", 128'(level), 128'(16));
    chk("t4_drop", 128'(drop_count), 128'(4));
    drain();
    for (int i = 0; i < 5; i++) begin
      rd = 1; addr = 9'(i); rd_data = $urandom;
      step();
    end
    idle();
    reset = 1;
    step();
    reset = 0;
    @(negedge clk);
    chk("t5_level", 128'(level), 128'(0));
    chk("t5_valid", 128'(tif.out_valid), 128'(0));
    chk("t5_drop", 128'(drop_count), 128'(0));
    chk("t5_ovf", 128'(overflow), 128'(0));
    wr = 1; rd = 1; addr = 9'h0AB; wr_data = 32'h1111; rd_data = 32'h2222;
    step();
    idle();
    @(negedge clk);
    chk("t5_ts_restart", 128'(tif.out_ts), 128'(0));
    chk("t5_wr_priority", 128'(tif.out_mem_rd), 128'(0));
    drain();
    tif.out_ready = 1;
    for (int i = 0; i < 40; i++) begin
      reg_write_sig = 1; reg_num = 5'($urandom_range(1, 31)); reg_data = $urandom;
      step();
    end
    idle();
    tif.out_ready = 0;
    @(negedge clk);
    chk("t6_level", 128'(level), 128'(1));
    drain();
    for (int i = 0; i < 3000; i++) begin
      trace_en      = ($urandom % 4) != 0;
      reg_write_sig = $urandom % 2;
      reg_num       = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom);
      reg_data      = $urandom;
      wr            = ($urandom % 3) == 0;
      rd            = ($urandom % 3) == 0;
      addr          = 9'($urandom);
      wr_data       = $urandom;
      rd_data       = $urandom;
      tif.out_ready = ($urandom % 100) < (((i / 300) % 2) ? 85 : 25);
      reset         = ($urandom % 700) == 0;
      step();
    end
    reset = 0; trace_en = 1;
    idle();
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
